// File: rtl/arm_pkg.sv
// Shared definitions for the 5-stage ARM core pipeline.
// Contents:
//   - ALU command encodings carried on exe_cmd
//   - NZCV bit positions within the 4-bit status snapshot
//   - shifter type codes (instruction bits [6:5])
//   - field widths for the shifter operand and the branch offset
//   - helper function for the memory-instruction flag
package arm_pkg;

  localparam int SHIFT_OP_W = 12;
  localparam int IMM24_W    = 24;
  localparam int EXE_CMD_W  = 4;
  localparam int STATUS_W   = 4;

  // ALU commands. CMP/TST share the SUB/AND datapath, and LDR/STR use
  // the adder to form the effective address.
  localparam logic [EXE_CMD_W-1:0] EXE_NOP     = 4'b0000;
  localparam logic [EXE_CMD_W-1:0] EXE_MOV     = 4'b0001;
  localparam logic [EXE_CMD_W-1:0] EXE_MVN     = 4'b1001;
  localparam logic [EXE_CMD_W-1:0] EXE_ADD     = 4'b0010;
  localparam logic [EXE_CMD_W-1:0] EXE_ADC     = 4'b0011;
  localparam logic [EXE_CMD_W-1:0] EXE_SUB     = 4'b0100;
  localparam logic [EXE_CMD_W-1:0] EXE_SBC     = 4'b0101;
  localparam logic [EXE_CMD_W-1:0] EXE_AND     = 4'b0110;
  localparam logic [EXE_CMD_W-1:0] EXE_ORR     = 4'b0111;
  localparam logic [EXE_CMD_W-1:0] EXE_EOR     = 4'b1000;
  localparam logic [EXE_CMD_W-1:0] EXE_CMP     = 4'b0100;
  localparam logic [EXE_CMD_W-1:0] EXE_TST     = 4'b0110;
  localparam logic [EXE_CMD_W-1:0] EXE_LDR_STR = 4'b0010;

  // NZCV bit indices.
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Shift types.
  localparam logic [1:0] SHIFT_LSL = 2'b00;
  localparam logic [1:0] SHIFT_LSR = 2'b01;
  localparam logic [1:0] SHIFT_ASR = 2'b10;
  localparam logic [1:0] SHIFT_ROR = 2'b11;

  // A real load or store; bubbles never count as memory instructions.
  function automatic logic is_mem_instr(input logic valid,
                                        input logic mem_read,
                                        input logic mem_write);
    return (mem_read | mem_write) & valid;
  endfunction

endpackage

// File: rtl/pipe_field_reg.sv
// Generic pipeline field register.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset, q -> 0
//   clear - synchronous clear to 0, wins over en (flush)
//   en    - load d on the edge when set (deasserted during a stall)
//   d     - next value
//   q     - stored value, driven straight from flops
module pipe_field_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clear) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register of the 5-stage ARM core.
// Captures the decoded instruction every cycle and presents it to EX.
// Ports:
//   clk, rst_n     - clock, asynchronous active-low reset (all outputs 0)
//   freeze         - hold every stored field (hazard stall)
//   flush          - load a bubble; takes priority over freeze
//   id_*           - decoded instruction from ID (id_valid=0 marks a bubble)
//   ex_*           - registered copies of id_* for EX
//   ex_mem_instr   - registered (mem_read | mem_write) & valid
// Handshake: there is no valid/ready pair here; id_valid qualifies the
// entry and is captured with it, freeze is the only back-pressure and
// flush overrides it. Every output comes straight from a flop.
module id_ex_stage_reg
  import arm_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  freeze,
  input  logic                  flush,
  input  logic                  id_valid,
  input  logic [DATA_W-1:0]     id_pc,
  input  logic [DATA_W-1:0]     id_val_rn,
  input  logic [DATA_W-1:0]     id_val_rm,
  input  logic [SHIFT_OP_W-1:0] id_shift_operand,
  input  logic                  id_imm,
  input  logic [IMM24_W-1:0]    id_signed_imm24,
  input  logic [REG_ADDR_W-1:0] id_dest,
  input  logic [REG_ADDR_W-1:0] id_src1,
  input  logic [REG_ADDR_W-1:0] id_src2,
  input  logic [EXE_CMD_W-1:0]  id_exe_cmd,
  input  logic                  id_mem_read,
  input  logic                  id_mem_write,
  input  logic                  id_wb_en,
  input  logic                  id_branch,
  input  logic                  id_s,
  input  logic [STATUS_W-1:0]   id_status,
  output logic                  ex_valid,
  output logic [DATA_W-1:0]     ex_pc,
  output logic [DATA_W-1:0]     ex_val_rn,
  output logic [DATA_W-1:0]     ex_val_rm,
  output logic [SHIFT_OP_W-1:0] ex_shift_operand,
  output logic                  ex_imm,
  output logic [IMM24_W-1:0]    ex_signed_imm24,
  output logic [REG_ADDR_W-1:0] ex_dest,
  output logic [REG_ADDR_W-1:0] ex_src1,
  output logic [REG_ADDR_W-1:0] ex_src2,
  output logic [EXE_CMD_W-1:0]  ex_exe_cmd,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write,
  output logic                  ex_wb_en,
  output logic                  ex_branch,
  output logic                  ex_s,
  output logic [STATUS_W-1:0]   ex_status,
  output logic                  ex_mem_instr
);

  localparam int DATA_GRP_W = 3*DATA_W + SHIFT_OP_W + 1 + IMM24_W + STATUS_W;
  localparam int CTRL_GRP_W = 1 + EXE_CMD_W + 6;
  localparam int IDX_GRP_W  = 3*REG_ADDR_W;

  logic                  load_en;
  logic [DATA_GRP_W-1:0] data_d, data_q;
  logic [CTRL_GRP_W-1:0] ctrl_d, ctrl_q;
  logic [IDX_GRP_W-1:0]  idx_d,  idx_q;

  assign load_en = ~freeze;

  // Side-effect controls are qualified by id_valid here, so a bubble can
  // never write memory, the register file or the flags, whatever ID left
  // on those wires. exe_cmd is informational and captured as-is.
  assign data_d = {id_pc, id_val_rn, id_val_rm, id_shift_operand, id_imm,
                   id_signed_imm24, id_status};
  assign ctrl_d = {id_valid, id_exe_cmd,
                   id_mem_read  & id_valid,
                   id_mem_write & id_valid,
                   id_wb_en     & id_valid,
                   id_branch    & id_valid,
                   id_s         & id_valid,
                   is_mem_instr(id_valid, id_mem_read, id_mem_write)};
  assign idx_d  = {id_dest, id_src1, id_src2};

  // Data fields are don't-care after a flush but are zeroed anyway so the
  // stored bubble is fully deterministic.
  pipe_field_reg #(.W(DATA_GRP_W)) u_data_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (flush),
    .en    (load_en),
    .d     (data_d),
    .q     (data_q)
  );

  pipe_field_reg #(.W(CTRL_GRP_W)) u_ctrl_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (flush),
    .en    (load_en),
    .d     (ctrl_d),
    .q     (ctrl_q)
  );

  // Register indices cleared on flush so forwarding never matches a bubble
  // against a stale destination.
  pipe_field_reg #(.W(IDX_GRP_W)) u_idx_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (flush),
    .en    (load_en),
    .d     (idx_d),
    .q     (idx_q)
  );

  assign {ex_pc, ex_val_rn, ex_val_rm, ex_shift_operand, ex_imm,
          ex_signed_imm24, ex_status} = data_q;
  assign {ex_valid, ex_exe_cmd, ex_mem_read, ex_mem_write, ex_wb_en,
          ex_branch, ex_s, ex_mem_instr} = ctrl_q;
  assign {ex_dest, ex_src1, ex_src2} = idx_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Self-checking bench for id_ex_stage_reg: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a
// behavioural model of the stage register.
module tb_id_ex_stage_reg;
  import arm_pkg::*;

  localparam int DW = 32;
  localparam int RW = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          freeze, flush, id_valid, id_imm;
  logic [DW-1:0] id_pc, id_val_rn, id_val_rm;
  logic [11:0]   id_shift_operand;
  logic [23:0]   id_signed_imm24;
  logic [RW-1:0] id_dest, id_src1, id_src2;
  logic [3:0]    id_exe_cmd, id_status;
  logic          id_mem_read, id_mem_write, id_wb_en, id_branch, id_s;

  logic          ex_valid, ex_imm;
  logic [DW-1:0] ex_pc, ex_val_rn, ex_val_rm;
  logic [11:0]   ex_shift_operand;
  logic [23:0]   ex_signed_imm24;
  logic [RW-1:0] ex_dest, ex_src1, ex_src2;
  logic [3:0]    ex_exe_cmd, ex_status;
  logic          ex_mem_read, ex_mem_write, ex_wb_en, ex_branch, ex_s, ex_mem_instr;

  id_ex_stage_reg #(.DATA_W(DW), .REG_ADDR_W(RW)) dut (
    .clk(clk), .rst_n(rst_n), .freeze(freeze), .flush(flush),
    .id_valid(id_valid), .id_pc(id_pc), .id_val_rn(id_val_rn),
    .id_val_rm(id_val_rm), .id_shift_operand(id_shift_operand),
    .id_imm(id_imm), .id_signed_imm24(id_signed_imm24), .id_dest(id_dest),
    .id_src1(id_src1), .id_src2(id_src2), .id_exe_cmd(id_exe_cmd),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_wb_en(id_wb_en), .id_branch(id_branch), .id_s(id_s),
    .id_status(id_status),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_val_rn(ex_val_rn),
    .ex_val_rm(ex_val_rm), .ex_shift_operand(ex_shift_operand),
    .ex_imm(ex_imm), .ex_signed_imm24(ex_signed_imm24), .ex_dest(ex_dest),
    .ex_src1(ex_src1), .ex_src2(ex_src2), .ex_exe_cmd(ex_exe_cmd),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_wb_en(ex_wb_en), .ex_branch(ex_branch), .ex_s(ex_s),
    .ex_status(ex_status), .ex_mem_instr(ex_mem_instr)
  );

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic          valid;
    logic [DW-1:0] pc, val_rn, val_rm;
    logic [11:0]   shift_operand;
    logic          imm;
    logic [23:0]   signed_imm24;
    logic [RW-1:0] dest, src1, src2;
    logic [3:0]    exe_cmd;
    logic          mem_read, mem_write, wb_en, branch, s;
    logic [3:0]    status;
    logic          mem_instr;
  } ex_t;

  ex_t exp_s;
  ex_t act_s;

  always_comb begin
    act_s = '{ex_valid, ex_pc, ex_val_rn, ex_val_rm, ex_shift_operand, ex_imm,
              ex_signed_imm24, ex_dest, ex_src1, ex_src2, ex_exe_cmd,
              ex_mem_read, ex_mem_write, ex_wb_en, ex_branch, ex_s,
              ex_status, ex_mem_instr};
  end

  // What EX must see after a normal capture of the current ID inputs:
  // a copy, with every side effect dropped for a bubble.
  function automatic ex_t captured();
    ex_t e;
    e.valid         = id_valid;
    e.pc            = id_pc;
    e.val_rn        = id_val_rn;
    e.val_rm        = id_val_rm;
    e.shift_operand = id_shift_operand;
    e.imm           = id_imm;
    e.signed_imm24  = id_signed_imm24;
    e.dest          = id_dest;
    e.src1          = id_src1;
    e.src2          = id_src2;
    e.exe_cmd       = id_exe_cmd;
    e.mem_read      = id_valid ? id_mem_read  : 1'b0;
    e.mem_write     = id_valid ? id_mem_write : 1'b0;
    e.wb_en         = id_valid ? id_wb_en     : 1'b0;
    e.branch        = id_valid ? id_branch    : 1'b0;
    e.s             = id_valid ? id_s         : 1'b0;
    e.status        = id_status;
    e.mem_instr     = id_valid && (id_mem_read || id_mem_write);
    return e;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)       exp_s <= '0;
    else if (flush)   exp_s <= '0;   // bubble, also discards a frozen entry
    else if (!freeze) exp_s <= captured();
  end

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic cmp_en = 1'b0;

  always @(negedge clk) begin
    if (cmp_en) begin
      n_tests++;
      if (act_s !== exp_s) begin
        n_fail++;
        $display("FAIL model_cycle t=%0t got=%h exp=%h", $time, act_s, exp_s);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%h exp=%h", name, $time, got, want);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    freeze = 0; flush = 0; id_valid = 1; id_pc = '0; id_val_rn = '0;
    id_val_rm = '0; id_shift_operand = '0; id_imm = 0; id_signed_imm24 = '0;
    id_dest = '0; id_src1 = '0; id_src2 = '0; id_exe_cmd = EXE_NOP;
    id_mem_read = 0; id_mem_write = 0; id_wb_en = 0; id_branch = 0; id_s = 0;
    id_status = '0;
  endtask

  task automatic drive_random();
    freeze = ($urandom_range(0, 9) < 2);
    flush  = ($urandom_range(0, 9) < 1);
    id_valid = ($urandom_range(0, 9) < 8);
    id_pc = $urandom; id_val_rn = $urandom; id_val_rm = $urandom;
    id_shift_operand = 12'($urandom); id_imm = 1'($urandom);
    id_signed_imm24 = 24'($urandom);
    id_dest = 4'($urandom); id_src1 = 4'($urandom); id_src2 = 4'($urandom);
    id_exe_cmd = 4'($urandom);
    id_mem_read = 1'($urandom); id_mem_write = 1'($urandom);
    id_wb_en = 1'($urandom); id_branch = 1'($urandom); id_s = 1'($urandom);
    id_status = 4'($urandom);
  endtask

  task automatic after_edge();
    @(posedge clk); #1;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    drive_idle();
    id_valid = 1; id_mem_read = 1; id_pc = 32'h1234_5678;
    #3;
    check("reset_valid", ex_valid, 0);
    check("reset_pc", ex_pc, 0);
    check("reset_mem_instr", ex_mem_instr, 0);

    // Normal capture on first edge after release.
    @(negedge clk);
    drive_idle();
    id_pc = 32'h0000_0010; id_shift_operand = 12'h1E3; id_imm = 1;
    id_mem_read = 1; id_valid = 1; id_exe_cmd = EXE_LDR_STR; id_wb_en = 1;
    rst_n = 1;
    cmp_en = 1;
    after_edge();
    check("cap_pc", ex_pc, 32'h10);
    check("cap_shift_op", ex_shift_operand, 12'h1E3);
    check("cap_imm", ex_imm, 1);
    check("cap_mem_instr", ex_mem_instr, 1);
    check("cap_valid", ex_valid, 1);

    // Freeze holds the entry for three cycles.
    @(negedge clk); drive_idle(); id_dest = 4'd5;
    after_edge();
    check("frz_pre_dest", ex_dest, 5);
    @(negedge clk); freeze = 1; id_dest = 4'd9; id_wb_en = 1;
    for (int i = 0; i < 3; i++) begin
      after_edge();
      check("frz_hold_dest", ex_dest, 5);
      check("frz_hold_wb", ex_wb_en, 0);
    end
    @(negedge clk); freeze = 0;
    after_edge();
    check("frz_release_dest", ex_dest, 9);

    // Flush a valid STR.
    @(negedge clk); drive_idle(); id_mem_write = 1; id_exe_cmd = EXE_LDR_STR;
    id_dest = 4'd3;
    after_edge();
    check("str_mem_write", ex_mem_write, 1);
    check("str_mem_instr", ex_mem_instr, 1);
    @(negedge clk); flush = 1;
    after_edge();
    check("fl_valid", ex_valid, 0);
    check("fl_mem_write", ex_mem_write, 0);
    check("fl_exe_cmd", ex_exe_cmd, 0);
    check("fl_mem_instr", ex_mem_instr, 0);
    check("fl_dest", ex_dest, 0);

    // Flush and freeze together: flush wins.
    @(negedge clk); drive_idle(); id_exe_cmd = EXE_ADD; id_wb_en = 1;
    id_dest = 4'd7;
    after_edge();
    check("add_wb", ex_wb_en, 1);
    @(negedge clk); flush = 1; freeze = 1;
    after_edge();
    check("flfrz_wb", ex_wb_en, 0);
    check("flfrz_valid", ex_valid, 0);
    // Second back-to-back flush edge.
    after_edge();
    check("fl2_valid", ex_valid, 0);
    check("fl2_dest", ex_dest, 0);

    // Bubble input drops side effects.
    @(negedge clk); drive_idle(); id_valid = 0; id_mem_write = 1;
    id_wb_en = 1; id_s = 1; id_exe_cmd = EXE_SUB; id_dest = 4'd2;
    after_edge();
    check("bub_mem_write", ex_mem_write, 0);
    check("bub_wb", ex_wb_en, 0);
    check("bub_s", ex_s, 0);
    check("bub_mem_instr", ex_mem_instr, 0);
    check("bub_exe_cmd", ex_exe_cmd, EXE_SUB);

    // Asynchronous reset mid-stall, between edges.
    @(negedge clk); drive_idle(); id_val_rm = 32'hDEAD_BEEF; id_wb_en = 1;
    after_edge();
    check("pre_rst_rm", ex_val_rm, 32'hDEAD_BEEF);
    @(negedge clk); freeze = 1;
    @(posedge clk); #2;
    rst_n = 0;
    #1;
    check("rst_rm", ex_val_rm, 0);
    check("rst_wb", ex_wb_en, 0);
    @(negedge clk); drive_idle(); id_val_rm = 32'h1234_ABCD; id_wb_en = 1;
    rst_n = 1;
    after_edge();
    check("post_rst_rm", ex_val_rm, 32'h1234_ABCD);
    check("post_rst_wb", ex_wb_en, 1);

    // Randomized traffic checked by the model every cycle.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      drive_random();
    end
    @(negedge clk);
    drive_idle();
    @(negedge clk);
    cmp_en = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
